// File: rtl/fp_int_converter_if.sv
// Valid/ready bundle for fp_int_converter.
// Ports: in_valid/in_ready/op/in_data request side,
//        out_valid/out_ready/out_data/out_flags result side.
interface fp_int_converter_if;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, op, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, op, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp_int_converter.sv
// int32 <-> IEEE754 single converter, truncating.
// Ports: clk, rst (sync, active high), bus (slave).
module fp_int_converter (
  input  logic            clk,
  input  logic            rst,
  fp_int_converter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, SHIFT, PACK, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] x_q, x_d;
  logic [31:0] m_q, m_d;
  logic [7:0]  e_q, e_d;
  logic        s_q, s_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        spec_q, spec_d;
  logic [2:0]  sfl_q, sfl_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [2:0]  out_flags_q, out_flags_d;

  logic        accept;
  logic        deliver;
  logic [31:0] mag;
  logic [7:0]  ex_m;
  logic [31:0] unp_m;
  logic [7:0]  unp_e;
  logic [5:0]  unp_n;
  logic        unp_left;
  logic        unp_spec;
  logic [2:0]  unp_fl;

  function automatic logic [5:0] lzc(
    input logic [31:0] v
  );
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++)
      if (v[i]) n = 6'(31 - i);
    return n;
  endfunction

  assign accept  = bus.in_valid & bus.in_ready;
  assign deliver = out_valid_q & bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      x_q         <= '0;
      m_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      spec_q      <= 1'b0;
      sfl_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      x_q         <= x_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      spec_q      <= spec_d;
      sfl_q       <= sfl_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

  // Operand decode, evaluated from the captured word.
  // The special-case chain is ordered: 0xCF000000 must
  // win over the generic exp >= 158 saturation.
  always_comb begin
    mag      = x_q[31] ? (~x_q + 32'd1) : x_q;
    ex_m     = x_q[30:23] - 8'd127;
    unp_m    = '0;
    unp_e    = '0;
    unp_n    = '0;
    unp_left = 1'b1;
    unp_spec = 1'b0;
    unp_fl   = '0;
    if (!op_q) begin
      unp_m = mag;
      unp_e = 8'd158;
      unp_n = lzc(mag);
    end else if (x_q[30:23] == 8'hFF &&
                 x_q[22:0] != 23'd0) begin
      unp_spec = 1'b1;
      unp_m    = 32'h7FFF_FFFF;
      unp_fl   = 3'b100;
    end else if (x_q == 32'hCF00_0000) begin
      unp_spec = 1'b1;
      unp_m    = 32'h8000_0000;
    end else if (x_q[30:23] >= 8'd158) begin
      unp_spec = 1'b1;
      unp_m    = x_q[31] ? 32'h8000_0000
                         : 32'h7FFF_FFFF;
      unp_fl   = 3'b010;
    end else if (x_q[30:23] < 8'd127) begin
      unp_spec = 1'b1;
      unp_fl   = {2'b00, |x_q[30:0]};
    end else begin
      unp_m = {8'd0, 1'b1, x_q[22:0]};
      if (ex_m >= 8'd23) begin
        unp_n = 6'(ex_m - 8'd23);
      end else begin
        unp_left = 1'b0;
        unp_n    = 6'(8'd23 - ex_m);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = UNPACK;
      UNPACK:
        state_d = (unp_n == 6'd0) ? PACK : SHIFT;
      SHIFT:
        if (cnt_q == 6'd1) state_d = PACK;
      PACK:
        state_d = DONE;
      DONE:
        if (deliver) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Outputs and datapath updates.
  always_comb begin
    bus.in_ready = (state_q == IDLE) & ~rst;
    // Result flops load in PACK; valid follows
    // one cycle later and drops on the handshake.
    out_valid_d  = (state_q == DONE) & ~deliver;
    op_d         = op_q;
    x_d          = x_q;
    m_d          = m_q;
    e_d          = e_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    left_d       = left_q;
    spec_d       = spec_q;
    sfl_d        = sfl_q;
    out_data_d   = out_data_q;
    out_flags_d  = out_flags_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = bus.op;
          x_d  = bus.in_data;
        end
      end
      UNPACK: begin
        m_d    = unp_m;
        e_d    = unp_e;
        s_d    = 1'b0;
        cnt_d  = unp_n;
        left_d = unp_left;
        spec_d = unp_spec;
        sfl_d  = unp_fl;
      end
      SHIFT: begin
        cnt_d = cnt_q - 6'd1;
        if (left_q) begin
          m_d = m_q << 1;
          if (!op_q) e_d = e_q - 8'd1;
        end else begin
          // Bits falling off the right are sticky.
          m_d = m_q >> 1;
          s_d = s_q | m_q[0];
        end
      end
      PACK: begin
        if (!op_q) begin
          if (m_q == 32'd0) begin
            out_data_d  = '0;
            out_flags_d = '0;
          end else begin
            out_data_d  = {x_q[31], e_q, m_q[30:8]};
            out_flags_d = {2'b00, |m_q[7:0]};
          end
        end else if (spec_q) begin
          out_data_d  = m_q;
          out_flags_d = sfl_q;
        end else begin
          out_data_d  = x_q[31] ? (~m_q + 32'd1) : m_q;
          out_flags_d = {2'b00, s_q};
        end
      end
      DONE: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fp_int_converter.sv
// Bench for fp_int_converter: fixed vectors, corner
// sequences and random ops against a value-level model.
module tb_fp_int_converter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fp_int_converter_if bus ();

  fp_int_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] x;
    logic [31:0] d;
    logic [2:0]  f;
    int          lat;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Truncating conversion from the numeric values.
  function automatic void ref_model(
    input  logic        o,
    input  logic [31:0] x,
    output logic [31:0] d,
    output logic [2:0]  f,
    output int          lat
  );
    longint mag, sig, val, lim;
    int     p, ex;
    logic   sn;
    sn  = x[31];
    d   = '0;
    f   = 3'b000;
    lat = 3;
    if (!o) begin
      mag = longint'($signed(x));
      if (mag < 0) mag = -mag;
      if (mag != 0) begin
        p = 31;
        while (mag < (longint'(1) << p)) p--;
        lat = 3 + (31 - p);
        if (p >= 23) begin
          sig  = mag >> (p - 23);
          f[0] = (mag % (longint'(1) << (p - 23)))
                 != 0;
        end else begin
          sig = mag << (23 - p);
        end
        d = {sn, 8'(127 + p), sig[22:0]};
      end
    end else begin
      ex  = int'(x[30:23]);
      sig = longint'({1'b1, x[22:0]});
      if (ex == 255 && x[22:0] != 0) begin
        d = 32'h7FFF_FFFF;
        f = 3'b100;
      end else if (ex >= 160) begin
        d = sn ? 32'h8000_0000 : 32'h7FFF_FFFF;
        f = 3'b010;
      end else if (ex < 127) begin
        f[0] = (x[30:0] != 0);
      end else begin
        if (ex >= 150) begin
          val = sig << (ex - 150);
        end else begin
          val  = sig >> (150 - ex);
          f[0] = (sig % (longint'(1) << (150 - ex)))
                 != 0;
        end
        lim = sn ? (longint'(1) << 31)
                 : (longint'(1) << 31) - 1;
        if (val > lim) begin
          d = sn ? 32'h8000_0000 : 32'h7FFF_FFFF;
          f = 3'b010;
        end else begin
          d = sn ? 32'(-val) : 32'(val);
          if (ex < 158)
            lat = 3 + ((ex >= 150) ? ex - 150
                                   : 150 - ex);
        end
      end
    end
  endfunction

  // Count edges after the accept edge until out_valid.
  task automatic wait_result(output int lat,
                             output logic [31:0] d,
                             output logic [2:0] f);
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = bus.out_data;
    f = bus.out_flags;
  endtask

  task automatic ack();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_op(input logic o,
                        input logic [31:0] x,
                        output int lat,
                        output logic [31:0] d,
                        output logic [2:0] f);
    int t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.in_data  = x;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50)
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = ~o;
    bus.in_data  = $urandom;
    wait_result(lat, d, f);
    ack();
  endtask

  initial begin
    int          lat, elat;
    logic [31:0] d, ed, hd;
    logic [2:0]  f, ef, hf;
    logic        o;
    logic [31:0] x;
    int          seen;

    n_cmp = 0;
    n_bad = 0;
    tbl[0]  = '{1'b0, 32'h0000_0001, 32'h3F80_0000,
                3'b000, 34};
    tbl[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0000,
                3'b000, 3};
    tbl[2]  = '{1'b0, 32'h8000_0000, 32'hCF00_0000,
                3'b000, 3};
    tbl[3]  = '{1'b0, 32'h0100_0001, 32'h4B80_0000,
                3'b001, 10};
    tbl[4]  = '{1'b1, 32'hC049_0FDB, 32'hFFFF_FFFD,
                3'b001, 25};
    tbl[5]  = '{1'b1, 32'h4B00_0000, 32'h0080_0000,
                3'b000, 3};
    tbl[6]  = '{1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF,
                3'b100, 3};
    tbl[7]  = '{1'b1, 32'h4F00_0000, 32'h7FFF_FFFF,
                3'b010, 3};
    tbl[8]  = '{1'b1, 32'hCF00_0000, 32'h8000_0000,
                3'b000, 3};
    tbl[9]  = '{1'b1, 32'h3F00_0000, 32'h0000_0000,
                3'b001, 3};
    tbl[10] = '{1'b0, 32'hFFFF_FFFF, 32'hBF80_0000,
                3'b000, 34};
    tbl[11] = '{1'b1, 32'hFF80_0000, 32'h8000_0000,
                3'b010, 3};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].x, lat, d, f);
      chk($sformatf("vec%0d_data", i), d, tbl[i].d);
      chk($sformatf("vec%0d_flags", i),
          32'(f), 32'(tbl[i].f));
      chk($sformatf("vec%0d_lat", i),
          32'(lat), 32'(tbl[i].lat));
    end

    // Backpressure with a pending request.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 1'b0;
    bus.in_data  = 32'h0100_0001;
    @(posedge clk);
    #1;
    bus.in_data = $urandom;
    wait_result(lat, hd, hf);
    chk("bp_lat", 32'(lat), 32'd10);
    chk("bp_data", hd, 32'h4B80_0000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.op      = 1'($urandom);
      bus.in_data = $urandom;
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data", bus.out_data, hd);
      chk("bp_hold_flags", 32'(bus.out_flags),
          32'(hf));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.op        = 1'b0;
    bus.in_data   = 32'h0000_0002;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_result(lat, d, f);
    chk("bp_next_data", d, 32'h4000_0000);
    chk("bp_next_lat", 32'(lat), 32'd33);
    ack();

    // Reset pulse in the middle of a long shift.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 1'b0;
    bus.in_data  = 32'h0000_0001;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_data", bus.out_data, 32'd0);
    run_op(1'b0, 32'h0000_0002, lat, d, f);
    chk("post_rst_data", d, 32'h4000_0000);
    chk("post_rst_flags", 32'(f), 32'd0);
    chk("post_rst_lat", 32'(lat), 32'd33);

    // Random operations against the model.
    for (int r = 0; r < 200; r++) begin
      o = 1'($urandom);
      if (!o) begin
        x = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) x = -x;
      end else if ($urandom_range(0, 7) == 0) begin
        x = $urandom;
      end else begin
        x = {1'($urandom),
             8'($urandom_range(120, 165)),
             23'($urandom)};
      end
      ref_model(o, x, ed, ef, elat);
      run_op(o, x, lat, d, f);
      chk($sformatf("rnd%0d_data_%h", r, x), d, ed);
      chk($sformatf("rnd%0d_flags_%h", r, x),
          32'(f), 32'(ef));
      chk($sformatf("rnd%0d_lat_%h", r, x),
          32'(lat), 32'(elat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
